// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_pkg
//  Purpose  : Shared constants and types for the multi-cycle mul/div sequencer
//  Revision : 1.0  initial release
// ============================================================================
package muldiv_pkg;

  localparam int XLEN = 32;

  // Operation codes understood by the external shared ALU
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLTU = 4'b0011;

  // funct3 encoding of the M-extension operations handled here
  localparam logic [2:0] MD_MUL  = 3'b000;
  localparam logic [2:0] MD_DIV  = 3'b100;
  localparam logic [2:0] MD_DIVU = 3'b101;
  localparam logic [2:0] MD_REM  = 3'b110;
  localparam logic [2:0] MD_REMU = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_NEG_IN_A = 3'd1,
    ST_NEG_IN_B = 3'd2,
    ST_MUL_IT   = 3'd3,
    ST_DIV_CMP  = 3'd4,
    ST_DIV_SUB  = 3'd5,
    ST_NEG_OUT  = 3'd6,
    ST_DONE     = 3'd7
  } state_e;

endpackage
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_seq
//  Purpose  : Iterative MUL/DIV/DIVU/REM/REMU engine that borrows one shared
//             combinational ALU, issuing one ALU operation per cycle.
//  Revision : 1.0  initial release
// ============================================================================
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter bit FASTPATH = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [2:0]      i_md_op,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [XLEN-1:0] o_rsp_data,
  output logic            o_busy,
  output logic [3:0]      o_alu_op,
  output logic [XLEN-1:0] o_alu_a,
  output logic [XLEN-1:0] o_alu_b,
  input  logic [XLEN-1:0] i_alu_data
);

  // a_q: multiplicand / dividend, b_q: multiplier / divisor,
  // acc_q: product accumulator / partial remainder, quo_q: quotient
  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [5:0]      cnt_q, cnt_d;
  logic            sign_a_q, sign_a_d;
  logic            sign_b_q, sign_b_d;
  logic            dvz_q, dvz_d;
  logic            lt_q, lt_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;

  logic [XLEN-1:0] shifted;
  logic            overflow_bit;
  logic            op_is_rem;
  logic            op_is_signed;
  logic            neg_result;
  logic [XLEN-1:0] neg_src;

  assign shifted      = {acc_q[XLEN-2:0], a_q[XLEN-1]};
  assign overflow_bit = acc_q[XLEN-1];
  assign op_is_rem    = op_q[1];
  assign op_is_signed = (op_q == MD_DIV) || (op_q == MD_REM);
  assign neg_src      = op_is_rem ? acc_q : quo_q;
  // Quotient sign fix-up is skipped for a zero divisor so the all-ones
  // result matches the fast path regardless of the dividend sign.
  assign neg_result   = op_is_rem ? sign_a_q : ((sign_a_q ^ sign_b_q) && !dvz_q);

  assign o_req_ready = (state_q == ST_IDLE);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;

  // Steer the shared ALU according to the current step; idle value is ADD 0,0
  always_comb begin
    o_alu_op = ALU_ADD;
    o_alu_a  = '0;
    o_alu_b  = '0;
    case (state_q)
      ST_NEG_IN_A: begin o_alu_op = ALU_SUB;  o_alu_a = '0;      o_alu_b = a_q;     end
      ST_NEG_IN_B: begin o_alu_op = ALU_SUB;  o_alu_a = '0;      o_alu_b = b_q;     end
      ST_MUL_IT:   begin o_alu_op = ALU_ADD;  o_alu_a = acc_q;   o_alu_b = a_q;     end
      ST_DIV_CMP:  begin o_alu_op = ALU_SLTU; o_alu_a = shifted; o_alu_b = b_q;     end
      ST_DIV_SUB:  begin o_alu_op = ALU_SUB;  o_alu_a = shifted; o_alu_b = b_q;     end
      ST_NEG_OUT:  begin o_alu_op = ALU_SUB;  o_alu_a = '0;      o_alu_b = neg_src; end
      default: ;
    endcase
  end

  // Next-state and datapath update for every sequencer step
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    dvz_d       = dvz_q;
    lt_d        = lt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (i_req_valid) begin
          op_d     = i_md_op;
          a_d      = i_op_a;
          b_d      = i_op_b;
          acc_d    = '0;
          quo_d    = '0;
          cnt_d    = 6'd31;
          sign_a_d = i_op_a[XLEN-1];
          sign_b_d = i_op_b[XLEN-1];
          dvz_d    = (i_op_b == '0);
          lt_d     = 1'b0;
          case (i_md_op)
            MD_MUL: state_d = ST_MUL_IT;
            MD_DIVU, MD_REMU, MD_DIV, MD_REM: begin
              if (FASTPATH && (i_op_b == '0)) begin
                state_d     = ST_DONE;
                rsp_valid_d = 1'b1;
                rsp_data_d  = i_md_op[1] ? i_op_a : '1;
              end else if (FASTPATH && !i_md_op[0] &&
                           (i_op_a == 32'h8000_0000) && (i_op_b == '1)) begin
                state_d     = ST_DONE;
                rsp_valid_d = 1'b1;
                rsp_data_d  = i_md_op[1] ? '0 : 32'h8000_0000;
              end else begin
                state_d = i_md_op[0] ? ST_DIV_CMP : ST_NEG_IN_A;
              end
            end
            default: begin
              state_d     = ST_DONE;
              rsp_valid_d = 1'b1;
              rsp_data_d  = '0;
            end
          endcase
        end
      end
      ST_NEG_IN_A: begin
        if (a_q[XLEN-1]) a_d = i_alu_data;
        state_d = ST_NEG_IN_B;
      end
      ST_NEG_IN_B: begin
        if (b_q[XLEN-1]) b_d = i_alu_data;
        state_d = ST_DIV_CMP;
      end
      ST_MUL_IT: begin
        if (b_q[0]) acc_d = i_alu_data;
        a_d = a_q << 1;
        b_d = b_q >> 1;
        if (cnt_q == 6'd0) begin
          state_d     = ST_DONE;
          rsp_valid_d = 1'b1;
          rsp_data_d  = acc_d;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      ST_DIV_CMP: begin
        lt_d    = !overflow_bit && i_alu_data[0];
        state_d = ST_DIV_SUB;
      end
      ST_DIV_SUB: begin
        acc_d = lt_q ? shifted : i_alu_data;
        quo_d = {quo_q[XLEN-2:0], !lt_q};
        a_d   = a_q << 1;
        if (cnt_q == 6'd0) begin
          if (op_is_signed) begin
            state_d = ST_NEG_OUT;
          end else begin
            state_d     = ST_DONE;
            rsp_valid_d = 1'b1;
            rsp_data_d  = op_is_rem ? acc_d : quo_d;
          end
        end else begin
          cnt_d   = cnt_q - 6'd1;
          state_d = ST_DIV_CMP;
        end
      end
      ST_NEG_OUT: begin
        state_d     = ST_DONE;
        rsp_valid_d = 1'b1;
        rsp_data_d  = neg_result ? i_alu_data : neg_src;
      end
      ST_DONE: begin
        if (i_rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with synchronous clear; reset abandons any operation
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      dvz_q       <= 1'b0;
      lt_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      dvz_q       <= dvz_d;
      lt_q        <= lt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_seq
//  Purpose  : Self-checking bench for muldiv_seq; instance 0 uses the fast
//             path for special cases, instance 1 iterates them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_seq;

  logic        clk;
  logic        rst;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [2:0]  md_op     [2];
  logic [31:0] op_a      [2];
  logic [31:0] op_b      [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_data  [2];
  logic        busy      [2];
  logic [3:0]  alu_op    [2];
  logic [31:0] alu_a     [2];
  logic [31:0] alu_b     [2];
  logic [31:0] alu_data  [2];

  int checks;
  int failures;

  muldiv_seq #(.FASTPATH(1'b1)) u_dut_fast (
    .i_clk(clk), .i_reset(rst),
    .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
    .i_md_op(md_op[0]), .i_op_a(op_a[0]), .i_op_b(op_b[0]),
    .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]), .o_rsp_data(rsp_data[0]),
    .o_busy(busy[0]), .o_alu_op(alu_op[0]), .o_alu_a(alu_a[0]), .o_alu_b(alu_b[0]),
    .i_alu_data(alu_data[0])
  );

  muldiv_seq #(.FASTPATH(1'b0)) u_dut_slow (
    .i_clk(clk), .i_reset(rst),
    .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
    .i_md_op(md_op[1]), .i_op_a(op_a[1]), .i_op_b(op_b[1]),
    .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]), .o_rsp_data(rsp_data[1]),
    .o_busy(busy[1]), .o_alu_op(alu_op[1]), .o_alu_a(alu_a[1]), .o_alu_b(alu_b[1]),
    .i_alu_data(alu_data[1])
  );

  // Behavioural shared ALU
  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0011: return {31'b0, (a < b)};
      default: return 32'h0;
    endcase
  endfunction

  always_comb alu_data[0] = alu_f(alu_op[0], alu_a[0], alu_b[0]);
  always_comb alu_data[1] = alu_f(alu_op[1], alu_a[1], alu_b[1]);

  // Architectural result of each operation
  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'b000: return a * b;
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b111: return (b == 0) ? a : a % b;
      3'b100: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : $unsigned(sa / sb);
      3'b110: return (b == 0) ? a : ovf ? 32'h0 : $unsigned(sa % sb);
      default: return 32'h0;
    endcase
  endfunction

  // Accept-to-valid latency in cycles
  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit fast);
    bit sgn;
    sgn = (op == 3'b100) || (op == 3'b110);
    if (op == 3'b000) return 33;
    if (op == 3'b001 || op == 3'b010 || op == 3'b011) return 1;
    if (fast && (b == 0)) return 1;
    if (fast && sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return sgn ? 68 : 65;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic start_op(input int d, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    @(negedge clk);
    req_valid[d] = 1'b1;
    md_op[d]     = op;
    op_a[d]      = a;
    op_b[d]      = b;
    while (!req_ready[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    md_op[d]     = 3'($urandom);
    op_a[d]      = $urandom;
    op_b[d]      = $urandom;
    chk($sformatf("accept_busy d%0d", d), {31'b0, busy[d]}, 32'd1);
  endtask

  task automatic wait_rsp(input int d, output int lat);
    lat = 1;
    while (!rsp_valid[d] && lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic take_rsp(input int d);
    @(negedge clk);
    rsp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[d] = 1'b0;
  endtask

  task automatic run_op(input int d, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat, input string tag);
    int lat;
    start_op(d, op, a, b);
    wait_rsp(d, lat);
    chk({tag, " data"}, rsp_data[d], exp);
    chk({tag, " latency"}, lat, exp_lat);
    take_rsp(d);
  endtask

  typedef struct {
    int          d;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs [19];
  logic [2:0] op_tab [10];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          d;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      rsp_ready[i] = 1'b0;
      md_op[i]     = 3'b0;
      op_a[i]      = 32'h0;
      op_b[i]      = 32'h0;
    end

    vecs[0]  = '{0, 3'b000, 32'd7,          32'd6,          32'd42,         33};
    vecs[1]  = '{0, 3'b000, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  33};
    vecs[2]  = '{0, 3'b101, 32'd100,        32'd7,          32'd14,         65};
    vecs[3]  = '{0, 3'b111, 32'd100,        32'd7,          32'd2,          65};
    vecs[4]  = '{0, 3'b101, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  65};
    vecs[5]  = '{0, 3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  68};
    vecs[6]  = '{0, 3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  68};
    vecs[7]  = '{0, 3'b100, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  68};
    vecs[8]  = '{0, 3'b110, 32'd7,          32'hFFFF_FFFE,  32'd1,          68};
    vecs[9]  = '{0, 3'b101, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[10] = '{0, 3'b111, 32'd5,          32'd0,          32'd5,          1};
    vecs[11] = '{0, 3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    vecs[12] = '{0, 3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          1};
    vecs[13] = '{1, 3'b101, 32'd5,          32'd0,          32'hFFFF_FFFF,  65};
    vecs[14] = '{1, 3'b111, 32'd5,          32'd0,          32'd5,          65};
    vecs[15] = '{1, 3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  68};
    vecs[16] = '{1, 3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          68};
    vecs[17] = '{0, 3'b010, 32'd123,        32'd45,         32'h0,          1};
    vecs[18] = '{1, 3'b000, 32'd3,          32'd5,          32'd15,         33};

    op_tab = '{3'b000, 3'b100, 3'b101, 3'b110, 3'b111, 3'b000, 3'b100, 3'b110, 3'b011, 3'b001};

    // Reset state of both instances
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset rsp_valid d%0d", i), {31'b0, rsp_valid[i]}, 32'd0);
      chk($sformatf("reset rsp_data d%0d", i),  rsp_data[i], 32'd0);
      chk($sformatf("reset busy d%0d", i),      {31'b0, busy[i]}, 32'd0);
      chk($sformatf("reset req_ready d%0d", i), {31'b0, req_ready[i]}, 32'd1);
      chk($sformatf("reset alu_op d%0d", i),    {28'b0, alu_op[i]}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 19; i++)
      run_op(vecs[i].d, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat,
             $sformatf("vec%0d", i));

    // Backpressure: result held, no new accept while DONE
    start_op(0, 3'b101, 32'd1000, 32'd9);
    wait_rsp(0, lat);
    chk("bp latency", lat, 32'd65);
    @(negedge clk);
    req_valid[0] = 1'b1;
    md_op[0]     = 3'b000;
    op_a[0]      = 32'd3;
    op_b[0]      = 32'd4;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp data c%0d", i),      rsp_data[0], 32'd111);
      chk($sformatf("bp rsp_valid c%0d", i), {31'b0, rsp_valid[0]}, 32'd1);
      chk($sformatf("bp req_ready c%0d", i), {31'b0, req_ready[0]}, 32'd0);
    end
    req_valid[0] = 1'b0;
    take_rsp(0);
    chk("bp after handshake valid", {31'b0, rsp_valid[0]}, 32'd0);
    chk("bp after handshake data",  rsp_data[0], 32'd111);
    chk("bp after handshake busy",  {31'b0, busy[0]}, 32'd0);

    // Back-to-back MULs: second accept one cycle after the handshake
    start_op(0, 3'b000, 32'd11, 32'd13);
    wait_rsp(0, lat);
    chk("b2b first data", rsp_data[0], 32'd143);
    chk("b2b first latency", lat, 32'd33);
    take_rsp(0);
    chk("b2b ready after handshake", {31'b0, req_ready[0]}, 32'd1);
    start_op(0, 3'b000, 32'd2, 32'd21);
    wait_rsp(0, lat);
    chk("b2b second data", rsp_data[0], 32'd42);
    chk("b2b second latency", lat, 32'd33);
    take_rsp(0);

    // Reset in the middle of a DIV, then a fresh MUL
    start_op(0, 3'b100, 32'hFFFF_FF00, 32'd3);
    repeat (22) @(posedge clk);
    #1;
    chk("mid-div busy", {31'b0, busy[0]}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst rsp_valid", {31'b0, rsp_valid[0]}, 32'd0);
    chk("rst rsp_data",  rsp_data[0], 32'd0);
    chk("rst busy",      {31'b0, busy[0]}, 32'd0);
    chk("rst req_ready", {31'b0, req_ready[0]}, 32'd1);
    chk("rst alu_op",    {28'b0, alu_op[0]}, 32'd0);
    chk("rst alu_a",     alu_a[0], 32'd0);
    chk("rst alu_b",     alu_b[0], 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(0, 3'b000, 32'd3, 32'd3, 32'd9, 33, "post-reset mul");

    // Randomised operations against the reference model
    for (int i = 0; i < 60; i++) begin
      d  = i % 2;
      op = op_tab[$urandom_range(0, 9)];
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 15))
        0, 1: b = 32'h0;
        2:    begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3:    b = b >> $urandom_range(1, 31);
        4:    a = a >> $urandom_range(1, 31);
        default: ;
      endcase
      run_op(d, op, a, b, ref_res(op, a, b), ref_lat(op, a, b, (d == 0)),
             $sformatf("rand%0d op%0d a=%h b=%h", i, op, a, b));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
